// File: rtl/uart_rx_controller_pkg.sv
// Shared definitions for the UART receive controller.
// State encodings and framing constants.
package uart_rx_controller_pkg;

    // 5.76 MHz / 115200 baud = 50 clk per bit
    localparam int UART_CLKS_PER_BIT = 50;
    localparam int UART_DATA_BITS    = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        WRITE = 3'd4,
        BREAK = 3'd5
    } rx_state_t;

endpackage

// File: rtl/uart_rx_controller_sync.sv
// Two-flop synchroniser for an asynchronous input.
// Resets to 1 so an idle-high line reads idle.
module uart_rx_sync (
    input  logic clk,
    input  logic reset_b,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx_controller.sv
// 8N1 UART receiver: mid-bit sampling, stop-bit check,
// one-cycle FIFO write strobe and error pulses.
module uart_rx_controller
    import uart_rx_controller_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
    parameter int CNT_W        = 6
) (
    input  logic       clk,
    input  logic       reset_b,
    input  logic       rx,
    input  logic       full,
    output logic [7:0] data_out,
    output logic       write_en,
    output logic       framing_error,
    output logic       overrun_error,
    output logic       busy
);

    localparam logic [CNT_W-1:0] HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    rx_state_t                     state;
    logic                          rx_s;
    logic [CNT_W-1:0]              cnt;
    logic [2:0]                    bit_idx;
    logic [UART_DATA_BITS-1:0]     shift;

    uart_rx_sync u_sync (
        .clk     (clk),
        .reset_b (reset_b),
        .d       (rx),
        .q       (rx_s)
    );

    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state         <= IDLE;
            cnt           <= '0;
            bit_idx       <= '0;
            shift         <= '0;
            data_out      <= '0;
            write_en      <= 1'b0;
            framing_error <= 1'b0;
            overrun_error <= 1'b0;
        end else begin
            write_en      <= 1'b0;
            framing_error <= 1'b0;
            overrun_error <= 1'b0;
            cnt           <= cnt + CNT_W'(1);
            unique case (state)
                IDLE: begin
                    cnt     <= '0;
                    bit_idx <= '0;
                    if (!rx_s)
                        state <= START;
                end
                START: begin
                    if (cnt == HALF) begin
                        cnt   <= '0;
                        state <= rx_s ? IDLE : DATA;
                    end
                end
                DATA: begin
                    if (cnt == LAST) begin
                        cnt     <= '0;
                        shift   <= {rx_s, shift[7:1]};
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7)
                            state <= STOP;
                    end
                end
                STOP: begin
                    if (cnt == LAST) begin
                        cnt <= '0;
                        if (!rx_s) begin
                            framing_error <= 1'b1;
                            state         <= BREAK;
                        end else if (full) begin
                            overrun_error <= 1'b1;
                            state         <= IDLE;
                        end else begin
                            data_out <= shift;
                            state    <= WRITE;
                        end
                    end
                end
                WRITE: begin
                    write_en <= 1'b1;
                    state    <= IDLE;
                end
                BREAK: begin
                    // a held-low line must not look like a new start bit
                    if (rx_s)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_controller.sv
// Directed bench for uart_rx_controller at 50 clk per bit.
module tb_uart_rx_controller;

    logic       clk = 1'b0;
    logic       reset_b = 1'b0;
    logic       rx = 1'b1;
    logic       full = 1'b0;
    logic [7:0] data_out;
    logic       write_en;
    logic       framing_error;
    logic       overrun_error;
    logic       busy;

    int vectors = 0;
    int errors  = 0;

    int cyc = 0;
    int wr_n = 0, fe_n = 0, oe_n = 0, busy_n = 0, multi_n = 0;
    int wr_cyc = 0, wr_cyc_p = 0, fe_cyc = 0, oe_cyc = 0;
    logic [7:0] wr_data = 8'h00, wr_data_p = 8'h00;

    int s;
    int w0, f0, o0, b0;

    uart_rx_controller #(.CLKS_PER_BIT(50), .CNT_W(6)) dut (
        .clk           (clk),
        .reset_b       (reset_b),
        .rx            (rx),
        .full          (full),
        .data_out      (data_out),
        .write_en      (write_en),
        .framing_error (framing_error),
        .overrun_error (overrun_error),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (write_en) begin
            wr_n++;
            wr_cyc_p  = wr_cyc;
            wr_data_p = wr_data;
            wr_cyc    = cyc;
            wr_data   = data_out;
        end
        if (framing_error) begin
            fe_n++;
            fe_cyc = cyc;
        end
        if (overrun_error) begin
            oe_n++;
            oe_cyc = cyc;
        end
        if (busy)
            busy_n++;
        if (32'(write_en) + 32'(framing_error) + 32'(overrun_error) > 1)
            multi_n++;
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic snap();
        w0 = wr_n;
        f0 = fe_n;
        o0 = oe_n;
        b0 = busy_n;
    endtask

    // call at a negedge; rx is left at the last driven level
    task automatic send_frame(input logic [7:0] b, input logic stop,
                              input int limit);
        logic [9:0] frame;
        frame = {stop, b, 1'b0};
        s = cyc;
        for (int c = 0; c < limit; c++) begin
            rx = frame[c / 50];
            @(negedge clk);
        end
    endtask

    task automatic good_frame(input string tag, input logic [7:0] b);
        snap();
        send_frame(b, 1'b1, 500);
        check({tag, "_wr_n"}, 32'(wr_n - w0), 32'd1);
        check({tag, "_wr_t"}, 32'(wr_cyc - s), 32'd479);
        check({tag, "_data"}, 32'(wr_data), 32'(b));
        check({tag, "_err"}, 32'((fe_n - f0) + (oe_n - o0)), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        @(negedge clk);
        check("rst_data", 32'(data_out), 32'h00);
        check("rst_strobes", {29'd0, write_en, framing_error, overrun_error}, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        repeat (3) @(negedge clk);
        reset_b = 1'b1;
        repeat (5) @(negedge clk);

        good_frame("a5", 8'hA5);

        snap();
        rx = 1'b0;
        repeat (10) @(negedge clk);
        rx = 1'b1;
        repeat (40) @(negedge clk);
        check("glitch_busy", 32'(busy_n - b0), 32'd25);
        check("glitch_strb", 32'((wr_n - w0) + (fe_n - f0) + (oe_n - o0)), 32'd0);
        good_frame("3c", 8'h3C);

        snap();
        send_frame(8'h3C, 1'b0, 500);
        check("fe_n", 32'(fe_n - f0), 32'd1);
        check("fe_t", 32'(fe_cyc - s), 32'd478);
        check("fe_wr", 32'(wr_n - w0), 32'd0);
        repeat (200) @(negedge clk);
        check("brk_busy", 32'(busy), 32'd1);
        check("brk_strb", 32'((wr_n - w0) + (fe_n - f0)), 32'd1);
        rx = 1'b1;
        repeat (4) @(negedge clk);
        check("brk_idle", 32'(busy), 32'd0);
        good_frame("55", 8'h55);

        snap();
        full = 1'b1;
        send_frame(8'h81, 1'b1, 500);
        full = 1'b0;
        check("oe_n", 32'(oe_n - o0), 32'd1);
        check("oe_t", 32'(oe_cyc - s), 32'd478);
        check("oe_wr", 32'(wr_n - w0), 32'd0);
        good_frame("81", 8'h81);

        snap();
        send_frame(8'h00, 1'b1, 500);
        send_frame(8'hFF, 1'b1, 500);
        check("b2b_n", 32'(wr_n - w0), 32'd2);
        check("b2b_d0", 32'(wr_data_p), 32'h00);
        check("b2b_d1", 32'(wr_data), 32'hFF);
        check("b2b_gap", 32'(wr_cyc - wr_cyc_p), 32'd500);

        snap();
        send_frame(8'hF0, 1'b1, 275);
        check("mid_busy", 32'(busy), 32'd1);
        rx = 1'b1;
        #2 reset_b = 1'b0;
        #1;
        check("arst_data", 32'(data_out), 32'h00);
        check("arst_strb", {29'd0, write_en, framing_error, overrun_error}, 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        repeat (3) @(negedge clk);
        reset_b = 1'b1;
        repeat (5) @(negedge clk);
        check("arst_none", 32'((wr_n - w0) + (fe_n - f0) + (oe_n - o0)), 32'd0);
        good_frame("0f", 8'h0F);

        check("exclusive", 32'(multi_n), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
